// File: rtl/onchip_ram_stream_writer.sv
// rtl/onchip_ram_stream_writer.sv - stream-to-RAM writer with one-shot and circular window capture
//
// Accepts a valid/ready stream of DATA_W-bit words, buffers them in a small
// skid FIFO and writes them into a window [base, base+len) of an on-chip RAM
// through a registered write port that honours mem_wait.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   ctrl_start/stop     capture start pulse / circular-mode stop pulse
//   ctrl_circular       1 = ring capture, 0 = one-shot (sampled at start)
//   ctrl_base/len       window base address and length in words (sampled at start)
//   in_valid/ready/data input stream handshake
//   mem_*               RAM slave write port (registered outputs), mem_wait stalls
//   st_*                busy/done/wrapped flags, write pointer and committed count
module onchip_ram_stream_writer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ctrl_start,
  input  logic                ctrl_stop,
  input  logic                ctrl_circular,
  input  logic [ADDR_W-1:0]   ctrl_base,
  input  logic [ADDR_W:0]     ctrl_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                mem_wait,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                st_busy,
  output logic                st_done,
  output logic                st_wrapped,
  output logic [ADDR_W-1:0]   st_wr_ptr,
  output logic [ADDR_W:0]     st_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BE_W  = DATA_W / 8;

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    IDX_ONE  = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic              circ_q;
  logic [ADDR_W:0]   accepted;

  // Skid FIFO; indices carry one extra bit to tell full from empty.
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_idx;
  logic [PTR_W:0]    rd_idx;

  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              commit;
  logic              pop;
  logic              wr_last;
  logic              start_ok;
  logic [ADDR_W-1:0] ptr_after;

  assign fifo_empty = (wr_idx == rd_idx);
  assign fifo_full  = (wr_idx[PTR_W] != rd_idx[PTR_W]) &&
                      (wr_idx[PTR_W-1:0] == rd_idx[PTR_W-1:0]);

  assign in_ready = (state == S_RUN) && !fifo_full && (circ_q || (accepted < len_q));
  assign accept   = in_valid && in_ready;
  assign commit   = mem_write && !mem_wait;
  // A new word may be presented when the port is free or is freeing up on this edge.
  assign pop      = (state != S_IDLE) && !fifo_empty && (!mem_write || commit);
  assign wr_last  = ({1'b0, st_wr_ptr} == (len_q - LEN_ONE));
  assign start_ok = ctrl_start && (ctrl_len != '0) && (ctrl_len <= MAX_LEN);

  // Write pointer as it stands after this edge; a back-to-back pop must use it.
  assign ptr_after = commit ? (wr_last ? '0 : st_wr_ptr + ADDR_ONE) : st_wr_ptr;

  assign mem_chipselect = mem_write;
  assign mem_byteenable = {BE_W{mem_write}};
  assign st_busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      circ_q        <= 1'b0;
      accepted      <= '0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      st_done       <= 1'b0;
      st_wrapped    <= 1'b0;
      st_wr_ptr     <= '0;
      st_count      <= '0;
    end else begin
      st_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            base_q     <= ctrl_base;
            len_q      <= ctrl_len;
            circ_q     <= ctrl_circular;
            accepted   <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            st_wr_ptr  <= '0;
            st_count   <= '0;
            st_wrapped <= 1'b0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (!circ_q && accept && ((accepted + LEN_ONE) == len_q)) begin
            state <= S_DRAIN;
          end else if (circ_q && ctrl_stop) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !mem_write) begin
            st_done <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        fifo_mem[wr_idx[PTR_W-1:0]] <= in_data;
        wr_idx                      <= wr_idx + IDX_ONE;
        accepted                    <= accepted + LEN_ONE;
      end

      if (pop) begin
        rd_idx        <= rd_idx + IDX_ONE;
        mem_write     <= 1'b1;
        mem_address   <= base_q + ptr_after;
        mem_writedata <= fifo_mem[rd_idx[PTR_W-1:0]];
      end else if (commit) begin
        mem_write <= 1'b0;
      end

      if (commit) begin
        st_wr_ptr <= ptr_after;
        if (st_count != len_q) begin
          st_count <= st_count + LEN_ONE;
        end
        if (circ_q && wr_last) begin
          st_wrapped <= 1'b1;
        end
      end
    end
  end

endmodule
